// File: rtl/sie_pkg.sv
// Shared SIE transmit definitions: packet type codes, PID codes, sequencer states.
package sie_pkg;

  typedef enum logic [1:0] {
    TYPE_TOKEN = 2'd0,
    TYPE_DATA  = 2'd1,
    TYPE_HS    = 2'd2,
    TYPE_RSVD  = 2'd3
  } pkt_type_e;

  localparam logic [7:0] SYNC_BYTE = 8'h80;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SOF   = 4'b0101;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  typedef enum logic [3:0] {
    ST_IDLE, ST_SYNC, ST_PID, ST_TOK1, ST_TOK2, ST_DATA, ST_CRC1, ST_CRC2, ST_GAP
  } state_e;

  function automatic logic [7:0] pid_byte(input logic [3:0] pid);
    return {~pid, pid};
  endfunction

endpackage

// File: rtl/sie_byte_timer.sv
// Mod-BYTE_CYCLES slot counter; flags the first and last clock of each byte slot.
module sie_byte_timer #(
  parameter int BYTE_CYCLES = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_slot_start,
  output logic o_slot_last
);
  localparam int CW = $clog2(BYTE_CYCLES);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) r_cnt <= '0;
    else if (i_en)         r_cnt <= o_slot_last ? '0 : r_cnt + CW'(1);
  end

  assign o_slot_start = (r_cnt == '0);
  assign o_slot_last  = (r_cnt == CW'(BYTE_CYCLES - 1));

endmodule

// File: rtl/sie_tx_sequencer.sv
// Packet sequencer feeding the SIE transmit path one byte per BYTE_CYCLES-clock slot.
module sie_tx_sequencer
  import sie_pkg::*;
#(
  parameter int BYTE_CYCLES = 8,
  parameter int LEN_W       = 4,
  parameter int GAP_BYTES   = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_type,
  input  logic [3:0]       req_pid,
  input  logic [6:0]       req_addr,
  input  logic [3:0]       req_endp,
  input  logic [LEN_W-1:0] req_len,
  input  logic [7:0]       pl_data,
  input  logic             pl_valid,
  output logic             pl_ready,
  output logic             load_SIE,
  output logic [7:0]       parallel_ip,
  output logic             busy,
  output logic             done,
  output logic             err_underrun,
  output logic             err_type
);
  localparam int GAP_W = $clog2(GAP_BYTES + 2);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_BYTES > 0) ? GAP_BYTES - 1 : 0);

  state_e           r_state, w_state_nxt;
  pkt_type_e        r_type;
  logic [3:0]       r_pid, r_endp;
  logic [6:0]       r_addr;
  logic [LEN_W-1:0] r_cnt, w_cnt_nxt;
  logic [GAP_W-1:0] r_gap, w_gap_nxt;
  logic [7:0]       r_byte, w_byte_nxt;
  logic             r_err_type, w_err_type_nxt;
  logic             w_accept, w_last_byte, w_end, w_to_data, w_pl_ready, w_req_ready;
  logic             w_slot_start, w_slot_last;

  sie_byte_timer #(.BYTE_CYCLES(BYTE_CYCLES)) u_timer (
    .i_clk        (clock),
    .i_rst_n      (reset),
    .i_en         (r_state != ST_IDLE),
    .i_clr        (r_state == ST_IDLE),
    .o_slot_start (w_slot_start),
    .o_slot_last  (w_slot_last)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_type     <= TYPE_TOKEN;
      r_pid      <= '0;
      r_addr     <= '0;
      r_endp     <= '0;
      r_cnt      <= '0;
      r_gap      <= '0;
      r_byte     <= '0;
      r_err_type <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_gap      <= w_gap_nxt;
      r_byte     <= w_byte_nxt;
      r_err_type <= w_err_type_nxt;
      if (w_accept) begin
        r_type <= pkt_type_e'(req_type);
        r_pid  <= req_pid;
        r_addr <= req_addr;
        r_endp <= req_endp;
        r_cnt  <= req_len;
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_gap_nxt      = r_gap;
    w_byte_nxt     = r_byte;
    w_err_type_nxt = 1'b0;
    w_accept       = 1'b0;
    w_to_data      = 1'b0;
    w_pl_ready     = 1'b0;

    case (r_state)
      ST_TOK2, ST_CRC2: w_last_byte = 1'b1;
      ST_PID:           w_last_byte = (r_type == TYPE_HS);
      default:          w_last_byte = 1'b0;
    endcase

    // Final slot of the whole packet: last byte when there is no gap, else last gap slot.
    w_end = w_slot_last && ((w_last_byte && (GAP_BYTES == 0)) ||
                            (r_state == ST_GAP && r_gap == '0));
    w_req_ready = (r_state == ST_IDLE) || w_end;

    if (r_state != ST_IDLE && w_slot_last) begin
      case (r_state)
        ST_SYNC: begin
          w_state_nxt = ST_PID;
          w_byte_nxt  = pid_byte(r_pid);
        end
        ST_PID: begin
          if (r_type == TYPE_TOKEN) begin
            w_state_nxt = ST_TOK1;
            w_byte_nxt  = {r_endp[0], r_addr};
          end else if (r_type == TYPE_DATA) begin
            w_to_data = 1'b1;
          end
        end
        ST_TOK1: begin
          w_state_nxt = ST_TOK2;
          w_byte_nxt  = {5'b0, r_endp[3:1]};
        end
        ST_DATA: w_to_data = 1'b1;
        ST_CRC1: begin
          w_state_nxt = ST_CRC2;
          w_byte_nxt  = 8'h00;
        end
        ST_GAP:  w_gap_nxt = r_gap - GAP_W'(1);
        default: ;
      endcase

      // Remaining count decides whether another payload byte follows.
      if (w_to_data) begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_CRC1;
          w_byte_nxt  = 8'h00;
        end else begin
          w_state_nxt = ST_DATA;
          w_cnt_nxt   = r_cnt - LEN_W'(1);
          w_pl_ready  = 1'b1;
          w_byte_nxt  = pl_valid ? pl_data : 8'h00;
        end
      end

      if (w_last_byte && GAP_BYTES > 0) begin
        w_state_nxt = ST_GAP;
        w_gap_nxt   = GAP_LAST;
      end
      if (w_end) w_state_nxt = ST_IDLE;
    end

    if (w_req_ready && req_valid) begin
      w_accept = 1'b1;
      if (req_type == TYPE_RSVD) begin
        w_err_type_nxt = 1'b1;
        w_state_nxt    = ST_IDLE;
      end else begin
        w_state_nxt = ST_SYNC;
        w_byte_nxt  = SYNC_BYTE;
      end
    end
  end

  assign req_ready    = w_req_ready;
  assign pl_ready     = w_pl_ready;
  assign err_underrun = w_pl_ready && !pl_valid;
  assign err_type     = r_err_type;
  assign load_SIE     = w_slot_start && (r_state != ST_IDLE) && (r_state != ST_GAP);
  assign parallel_ip  = r_byte;
  assign busy         = (r_state != ST_IDLE);
  assign done         = w_slot_last && w_last_byte;

endmodule

// File: tb/tb_sie_tx_sequencer.sv
// Directed bench for sie_tx_sequencer: byte streams, slot timing, underrun, reserved type, reset.
module tb_sie_tx_sequencer;
  import sie_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       req_valid = 1'b0, req_ready;
  logic [1:0] req_type = '0;
  logic [3:0] req_pid = '0, req_endp = '0, req_len = '0;
  logic [6:0] req_addr = '0;
  logic [7:0] pl_data = '0, parallel_ip;
  logic       pl_valid = 1'b0, pl_ready;
  logic       load_SIE, busy, done, err_underrun, err_type;

  sie_tx_sequencer dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
    .req_pid(req_pid), .req_addr(req_addr), .req_endp(req_endp), .req_len(req_len),
    .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready),
    .load_SIE(load_SIE), .parallel_ip(parallel_ip), .busy(busy), .done(done),
    .err_underrun(err_underrun), .err_type(err_type)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [7:0] ld_b[$];
  int ld_c[$], acc_c[$], done_c[$], prdy_c[$], und_c[$], et_c[$];
  int rr_low = 0, busy_hi = 0;
  logic [7:0] exp_q[$];

  always @(negedge clock) begin
    if (load_SIE) begin ld_b.push_back(parallel_ip); ld_c.push_back(cyc); end
    if (req_valid && req_ready) acc_c.push_back(cyc);
    if (done)         done_c.push_back(cyc);
    if (pl_ready)     prdy_c.push_back(cyc);
    if (err_underrun) und_c.push_back(cyc);
    if (err_type)     et_c.push_back(cyc);
    if (!req_ready)   rr_low++;
    if (busy)         busy_hi++;
  end

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_logs();
    ld_b.delete(); ld_c.delete(); acc_c.delete(); done_c.delete();
    prdy_c.delete(); und_c.delete(); et_c.delete(); exp_q.delete();
    rr_low = 0; busy_hi = 0;
  endtask

  task automatic send(input logic [1:0] t, input logic [3:0] pid, input logic [6:0] a,
                      input logic [3:0] e, input logic [3:0] len);
    int n;
    req_type = t; req_pid = pid; req_addr = a; req_endp = e; req_len = len;
    req_valid = 1'b1;
    n = 0;
    do begin @(negedge clock); n++; end while (!req_ready && n < 200);
    chk("accept", {31'd0, req_ready}, 32'd1);
    @(posedge clock); #1;
    req_valid = 1'b0;
    req_type = 2'($urandom); req_pid = 4'($urandom); req_addr = 7'($urandom);
    req_endp = 4'($urandom); req_len = 4'($urandom);
  endtask

  task automatic chk_bytes(input string tag, input int acc);
    chk({tag, "_nload"}, ld_b.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < ld_b.size(); i++) begin
      chk($sformatf("%s_b%0d", tag, i), {24'd0, ld_b[i]}, {24'd0, exp_q[i]});
      chk($sformatf("%s_t%0d", tag, i), ld_c[i] - acc, 1 + 8 * i);
    end
  endtask

  function automatic int q0(input int q[$]);
    return (q.size() > 0) ? q[0] : -1;
  endfunction

  int acc;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_load", load_SIE, 0);
    chk("rst_byte", parallel_ip, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_pl_ready", pl_ready, 0);
    chk("rst_errs", {err_underrun, err_type}, 0);
    @(posedge clock); #1 reset = 1'b1;
    repeat (2) @(posedge clock); #1;

    // TOKEN IN addr 0x16 endp 6
    clr_logs();
    send(TYPE_TOKEN, PID_IN, 7'h16, 4'd6, 4'd0);
    repeat (40) @(posedge clock); #1;
    acc = q0(acc_c);
    exp_q = '{8'h80, 8'h69, 8'h16, 8'h03};
    chk_bytes("tok", acc);
    chk("tok_ndone", done_c.size(), 1);
    chk("tok_done_t", q0(done_c) - acc, 32);
    chk("tok_busy_cycles", busy_hi, 32);

    // DATA0 len 1, payload available
    clr_logs();
    pl_data = 8'h62; pl_valid = 1'b1;
    send(TYPE_DATA, PID_DATA0, 7'h00, 4'd0, 4'd1);
    repeat (45) @(posedge clock); #1;
    acc = q0(acc_c);
    exp_q = '{8'h80, 8'hC3, 8'h62, 8'h00, 8'h00};
    chk_bytes("d0", acc);
    chk("d0_nprdy", prdy_c.size(), 1);
    chk("d0_prdy_t", q0(prdy_c) - acc, 16);
    chk("d0_done_t", q0(done_c) - acc, 40);
    chk("d0_nund", und_c.size(), 0);

    // HANDSHAKE ACK with a TOKEN OUT queued behind it
    clr_logs();
    send(TYPE_HS, PID_ACK, 7'h00, 4'd0, 4'd0);
    send(TYPE_TOKEN, PID_OUT, 7'h7F, 4'd9, 4'd0);
    repeat (40) @(posedge clock); #1;
    acc = q0(acc_c);
    exp_q = '{8'h80, 8'hD2, 8'h80, 8'hE1, 8'hFF, 8'h04};
    chk_bytes("hs", acc);
    chk("hs_nacc", acc_c.size(), 2);
    chk("hs_acc2_t", (acc_c.size() > 1 ? acc_c[1] : -1) - acc, 16);
    chk("hs_done0_t", q0(done_c) - acc, 16);

    // DATA1 len 2, second payload byte missing
    clr_logs();
    pl_data = 8'hA5; pl_valid = 1'b1;
    send(TYPE_DATA, PID_DATA1, 7'h00, 4'd0, 4'd2);
    repeat (16) @(posedge clock); #1 pl_valid = 1'b0;
    repeat (40) @(posedge clock); #1;
    acc = q0(acc_c);
    exp_q = '{8'h80, 8'h4B, 8'hA5, 8'h00, 8'h00, 8'h00};
    chk_bytes("d1", acc);
    chk("d1_nprdy", prdy_c.size(), 2);
    chk("d1_nund", und_c.size(), 1);
    chk("d1_und_t", q0(und_c) - acc, 24);
    chk("d1_done_t", q0(done_c) - acc, 48);

    // Reset mid-DATA, three clocks after the first payload load
    clr_logs();
    pl_data = 8'h5A; pl_valid = 1'b1;
    send(TYPE_DATA, PID_DATA0, 7'h00, 4'd0, 4'd3);
    acc = q0(acc_c);
    repeat (19) @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("mid_pre_byte", parallel_ip, 8'h5A);
    chk("mid_pre_busy", busy, 1);
    @(negedge clock);
    chk("mid_load", load_SIE, 0);
    chk("mid_byte", parallel_ip, 0);
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_req_ready", req_ready, 1);
    @(posedge clock); #1 reset = 1'b1;
    repeat (3) @(posedge clock); #1;
    chk("mid_ndone", done_c.size(), 0);
    clr_logs();
    send(TYPE_TOKEN, PID_OUT, 7'h01, 4'd0, 4'd0);
    repeat (40) @(posedge clock); #1;
    acc = q0(acc_c);
    exp_q = '{8'h80, 8'hE1, 8'h01, 8'h00};
    chk_bytes("post", acc);

    // Reserved request type
    clr_logs();
    send(TYPE_RSVD, PID_ACK, 7'h00, 4'd0, 4'd0);
    repeat (20) @(posedge clock); #1;
    acc = q0(acc_c);
    chk("rsv_net", et_c.size(), 1);
    chk("rsv_et_t", q0(et_c) - acc, 1);
    chk("rsv_nload", ld_b.size(), 0);
    chk("rsv_rr_low", rr_low, 0);
    chk("rsv_busy", busy_hi, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
